// File: rtl/imem_loader_pkg.sv
// -----------------------------------------------------------------------------
// imem_loader_pkg
// Shared definitions for the instruction-memory program loader:
//   - state_t           : loader FSM states
//   - LEN_BYTES         : bytes in the length header (16-bit word count)
//   - WORD_BYTES        : bytes per instruction word
//   - LEN_W             : width of the length header / word counter
//   - MAX_WORDS_DEFAULT : default largest accepted program length in words
// -----------------------------------------------------------------------------
package imem_loader_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LEN_LO = 3'd1,
        S_LEN_HI = 3'd2,
        S_DATA   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5,
        S_ERR    = 3'd6
    } state_t;

    localparam int LEN_BYTES         = 2;
    localparam int WORD_BYTES        = 4;
    localparam int LEN_W             = 8 * LEN_BYTES;
    localparam int MAX_WORDS_DEFAULT = 16384;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// -----------------------------------------------------------------------------
// byte_packer
// Packs a little-endian byte stream into WORD_BYTES-wide words. Byte k of a
// word lands in bits [8k+7:8k]; the byte counter wraps after the last byte.
// Ports:
//   i_clk        clock
//   i_rst_n      asynchronous active-low reset (clears counter and word)
//   i_clear      synchronous clear of counter and word (new load)
//   i_accept     a byte is transferred this cycle
//   i_byte       the byte being transferred
//   o_word       assembled word (held until overwritten)
//   o_word_full  one-cycle pulse when the last byte of a word is accepted
// -----------------------------------------------------------------------------
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_clear,
    input  logic                    i_accept,
    input  logic [7:0]              i_byte,
    output logic [8*WORD_BYTES-1:0] o_word,
    output logic                    o_word_full
);

    localparam int CNT_W = $clog2(WORD_BYTES);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_clear) begin
            r_cnt <= '0;
        end else if (i_accept) begin
            r_cnt <= r_cnt + 1'b1;  // natural wrap after the last byte
        end
    end

    // One register per byte lane; a lane loads only when the counter points at it.
    for (genvar gi = 0; gi < WORD_BYTES; gi++) begin : g_lane
        logic [7:0] r_lane;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) begin
                r_lane <= '0;
            end else if (i_clear) begin
                r_lane <= '0;
            end else if (i_accept && (r_cnt == CNT_W'(gi))) begin
                r_lane <= i_byte;
            end
        end

        assign o_word[8*gi +: 8] = r_lane;
    end

    assign o_word_full = i_accept && !i_clear && (r_cnt == CNT_W'(WORD_BYTES - 1));

endmodule

// File: rtl/imem_loader.sv
// -----------------------------------------------------------------------------
// imem_loader
// Loads a program into instruction memory from a byte stream and holds the CPU
// in reset until the load completes. Stream: 16-bit word count N (LSB first),
// then N little-endian 32-bit words written to word addresses 0..N-1.
// Ports:
//   i_clk         clock
//   i_rst_n       asynchronous active-low reset
//   i_start       one-cycle pulse starting a load (honoured in IDLE/DONE/ERR)
//   i_in_valid    stream byte valid
//   i_in_data     stream byte
//   o_in_ready    loader accepts a byte this cycle (decoded from state)
//   o_imem_we     instruction-memory write strobe, one cycle per word
//   o_imem_addr   word address of the write
//   o_imem_wdata  word to write
//   o_cpu_hold    CPU held in reset; low only once a load is done
//   o_done        load completed (sticky level)
//   o_err         length header exceeded MAX_WORDS (sticky level)
// -----------------------------------------------------------------------------
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W    = 14,
    parameter int MAX_WORDS = MAX_WORDS_DEFAULT
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic              i_in_valid,
    input  logic [7:0]        i_in_data,
    output logic              o_in_ready,
    output logic              o_imem_we,
    output logic [ADDR_W-1:0] o_imem_addr,
    output logic [31:0]       o_imem_wdata,
    output logic              o_cpu_hold,
    output logic              o_done,
    output logic              o_err
);

    state_t           r_state;
    state_t           w_state_next;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_word_cnt;

    logic             w_xfer;
    logic             w_start_ok;
    logic             w_word_full;
    logic [LEN_W-1:0] w_len_full;
    logic             w_len_too_big;
    logic             w_last_word;

    assign w_xfer        = i_in_valid && o_in_ready;
    assign w_start_ok    = i_start &&
                           ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
    // High byte arrives in LEN_HI; decide on the complete count in that same cycle.
    assign w_len_full    = {i_in_data, r_len[7:0]};
    assign w_len_too_big = ({16'd0, w_len_full} > 32'(MAX_WORDS));
    assign w_last_word   = ((r_word_cnt + LEN_W'(1)) == r_len);

    byte_packer u_packer (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_clear     (w_start_ok),
        .i_accept    (w_xfer && (r_state == S_DATA)),
        .i_byte      (i_in_data),
        .o_word      (o_imem_wdata),
        .o_word_full (w_word_full)
    );

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        w_state_next = r_state;
        o_in_ready   = 1'b0;
        o_imem_we    = 1'b0;
        o_done       = 1'b0;
        o_err        = 1'b0;
        o_cpu_hold   = 1'b1;

        case (r_state)
            S_IDLE: begin
                if (i_start) w_state_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                o_in_ready = 1'b1;
                if (w_xfer) w_state_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                o_in_ready = 1'b1;
                if (w_xfer) begin
                    if (w_len_full == '0)  w_state_next = S_DONE;
                    else if (w_len_too_big) w_state_next = S_ERR;
                    else                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                o_in_ready = 1'b1;
                if (w_word_full) w_state_next = S_WRITE;
            end
            S_WRITE: begin
                o_imem_we    = 1'b1;
                w_state_next = w_last_word ? S_DONE : S_DATA;
            end
            S_DONE: begin
                o_done     = 1'b1;
                o_cpu_hold = 1'b0;
                if (i_start) w_state_next = S_LEN_LO;
            end
            S_ERR: begin
                o_err = 1'b1;
                if (i_start) w_state_next = S_LEN_LO;
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Length header and word counter
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_len      <= '0;
            r_word_cnt <= '0;
        end else begin
            if (w_start_ok) begin
                r_word_cnt <= '0;
            end
            if ((r_state == S_LEN_LO) && w_xfer) begin
                r_len[7:0] <= i_in_data;
            end
            if ((r_state == S_LEN_HI) && w_xfer) begin
                r_len[15:8] <= i_in_data;
                r_word_cnt  <= '0;
            end
            if (r_state == S_WRITE) begin
                r_word_cnt <= r_word_cnt + LEN_W'(1);
            end
        end
    end

    assign o_imem_addr = r_word_cnt[ADDR_W-1:0];

endmodule

// File: tb/tb_imem_loader.sv
// -----------------------------------------------------------------------------
// tb_imem_loader
// Table-driven bench for imem_loader (built with MAX_WORDS=4 so the length
// limit is reachable). Each table entry is a complete load: the byte stream,
// optional random valid gaps, an optional ignored start pulse mid-stream, and
// the expected writes and final done/err levels. A monitor records every
// write strobe together with in_ready and whether the strobe lasted a cycle.
// Hand-written sequences cover reset values and reset in the middle of a load.
// -----------------------------------------------------------------------------
module tb_imem_loader;

    localparam int NV = 10;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        in_ready;
    logic        imem_we;
    logic [13:0] imem_addr;
    logic [31:0] imem_wdata;
    logic        cpu_hold;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    imem_loader #(.ADDR_W(14), .MAX_WORDS(4)) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_start      (start),
        .i_in_valid   (in_valid),
        .i_in_data    (in_data),
        .o_in_ready   (in_ready),
        .o_imem_we    (imem_we),
        .o_imem_addr  (imem_addr),
        .o_imem_wdata (imem_wdata),
        .o_cpu_hold   (cpu_hold),
        .o_done       (done),
        .o_err        (err)
    );

    // ---------------- write monitor ----------------
    typedef struct {
        logic [13:0] addr;
        logic [31:0] data;
        logic        rdy;
        logic        b2b;
    } wr_t;

    wr_t  wq[$];
    logic prev_we = 1'b0;

    always @(negedge clk) begin
        if (imem_we === 1'b1) wq.push_back('{imem_addr, imem_wdata, in_ready, prev_we});
        prev_we <= imem_we;
    end

    // ---------------- vector table ----------------
    typedef struct {
        string             name;
        int                nbytes;
        logic [17:0][7:0]  b;
        bit                gaps;
        int                start_at;
        int                nw;
        logic [3:0][31:0]  wd;
        bit                exp_err;
    } vec_t;

    vec_t vecs[NV];

    // Byte and word lists are given first-item-leftmost in a concatenation.
    task automatic mk(input int vi, input string nm, input int n, input logic [143:0] bl,
                      input bit gaps, input int sa, input int nw, input logic [127:0] wds,
                      input bit e);
        vecs[vi].name     = nm;
        vecs[vi].nbytes   = n;
        vecs[vi].gaps     = gaps;
        vecs[vi].start_at = sa;
        vecs[vi].nw       = nw;
        vecs[vi].exp_err  = e;
        vecs[vi].b        = '0;
        vecs[vi].wd       = '0;
        for (int k = 0; k < n; k++)  vecs[vi].b[k]  = bl[8*(n-1-k) +: 8];
        for (int j = 0; j < nw; j++) vecs[vi].wd[j] = wds[32*(nw-1-j) +: 32];
    endtask

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] bv);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = bv;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready === 1'b1) begin
                @(posedge clk); #1;
                ok = 1'b1;
                break;
            end
        end
        in_valid = 1'b0;
        chk("handshake_timeout", 32'(ok), 32'd1);
    endtask

    task automatic run_vec(input int vi);
        int base;
        int got;
        base = wq.size();
        pulse_start();
        chk({vecs[vi].name, "_hold_during"}, 32'(cpu_hold), 32'd1);
        chk({vecs[vi].name, "_done_during"}, 32'(done), 32'd0);
        chk({vecs[vi].name, "_ready_len"},   32'(in_ready), 32'd1);
        for (int k = 0; k < vecs[vi].nbytes; k++) begin
            if (k == vecs[vi].start_at) pulse_start();
            if (vecs[vi].gaps) begin
                repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            end
            send_byte(vecs[vi].b[k]);
        end
        if (vecs[vi].nw > 0) begin
            chk({vecs[vi].name, "_we_latency"}, 32'(imem_we), 32'd1);
            chk({vecs[vi].name, "_done_early"}, 32'(done), 32'd0);
            @(posedge clk); #1;
        end
        chk({vecs[vi].name, "_done"}, 32'(done), 32'(!vecs[vi].exp_err));
        chk({vecs[vi].name, "_err"},  32'(err),  32'(vecs[vi].exp_err));
        chk({vecs[vi].name, "_hold"}, 32'(cpu_hold), 32'(vecs[vi].exp_err));
        repeat (3) begin @(posedge clk); #1; end
        chk({vecs[vi].name, "_sticky"}, 32'({done, err}), 32'({!vecs[vi].exp_err, vecs[vi].exp_err}));
        got = wq.size() - base;
        chk({vecs[vi].name, "_nwrites"}, 32'(got), 32'(vecs[vi].nw));
        for (int j = 0; j < vecs[vi].nw && j < got; j++) begin
            chk({vecs[vi].name, "_addr"},  32'(wq[base+j].addr), 32'(j));
            chk({vecs[vi].name, "_data"},  wq[base+j].data, vecs[vi].wd[j]);
            chk({vecs[vi].name, "_ready_at_we"}, 32'(wq[base+j].rdy), 32'd0);
            chk({vecs[vi].name, "_we_one_cycle"}, 32'(wq[base+j].b2b), 32'd0);
        end
        $display("vec %-12s writes %0d done %b err %b hold %b", vecs[vi].name, got, done, err, cpu_hold);
    endtask

    // ---------------- bound on total run time ----------------
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    // ---------------- main ----------------
    initial begin
        rst_n    = 1'b0;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;

        mk(0, "two_word",  10, {8'h02,8'h00,8'h13,8'h05,8'h10,8'h00,8'h93,8'h05,8'h20,8'h00},
           1'b0, -1, 2, {32'h00100513, 32'h00200593}, 1'b0);
        mk(1, "zero_len",   2, {8'h00,8'h00}, 1'b0, -1, 0, 128'h0, 1'b0);
        mk(2, "oversize",   2, {8'h05,8'h00}, 1'b0, -1, 0, 128'h0, 1'b1);
        mk(3, "after_err",  6, {8'h01,8'h00,8'hEF,8'hBE,8'hAD,8'hDE},
           1'b0, -1, 1, {32'hDEADBEEF}, 1'b0);
        mk(4, "backpress", 10, {8'h02,8'h00,8'h13,8'h05,8'h10,8'h00,8'h93,8'h05,8'h20,8'h00},
           1'b1, -1, 2, {32'h00100513, 32'h00200593}, 1'b0);
        mk(5, "max_len",   18, {8'h04,8'h00,8'h01,8'h02,8'h03,8'h04,8'h05,8'h06,8'h07,8'h08,
                                8'h09,8'h0A,8'h0B,8'h0C,8'h0D,8'h0E,8'h0F,8'h10},
           1'b0, -1, 4, {32'h04030201, 32'h08070605, 32'h0C0B0A09, 32'h100F0E0D}, 1'b0);
        mk(6, "len_hi_big", 2, {8'h00,8'h01}, 1'b0, -1, 0, 128'h0, 1'b1);
        mk(7, "start_mid", 10, {8'h02,8'h00,8'h13,8'h05,8'h10,8'h00,8'h93,8'h05,8'h20,8'h00},
           1'b0, 3, 2, {32'h00100513, 32'h00200593}, 1'b0);
        mk(8, "two_word2", 10, {8'h02,8'h00,8'h13,8'h05,8'h10,8'h00,8'h93,8'h05,8'h20,8'h00},
           1'b0, -1, 2, {32'h00100513, 32'h00200593}, 1'b0);
        mk(9, "reload",     6, {8'h01,8'h00,8'hEF,8'hBE,8'hAD,8'hDE},
           1'b0, -1, 1, {32'hDEADBEEF}, 1'b0);

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_we",    32'(imem_we), 32'd0);
        chk("rst_addr",  32'(imem_addr), 32'd0);
        chk("rst_wdata", imem_wdata, 32'd0);
        chk("rst_hold",  32'(cpu_hold), 32'd1);
        chk("rst_done",  32'(done), 32'd0);
        chk("rst_err",   32'(err), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle_ready", 32'(in_ready), 32'd0);

        for (int vi = 0; vi < NV; vi++) run_vec(vi);

        // Reset in the middle of a load: six bytes complete word 0, so the
        // loader is in its write cycle when reset hits.
        pulse_start();
        send_byte(8'h02); send_byte(8'h00);
        send_byte(8'h13); send_byte(8'h05); send_byte(8'h10); send_byte(8'h00);
        chk("midrst_pre_we", 32'(imem_we), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midrst_we",    32'(imem_we), 32'd0);
        chk("midrst_hold",  32'(cpu_hold), 32'd1);
        chk("midrst_ready", 32'(in_ready), 32'd0);
        chk("midrst_addr",  32'(imem_addr), 32'd0);
        chk("midrst_done",  32'(done), 32'd0);
        $display("seq mid_reset we %b hold %b ready %b", imem_we, cpu_hold, in_ready);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        chk("midrst_idle_ready", 32'(in_ready), 32'd0);
        chk("midrst_idle_hold",  32'(cpu_hold), 32'd1);
        run_vec(0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
